// File: rtl/weight_loader.sv
// Weight tile loader: on start, reads FIFO_DEPTH rows from weight SRAM at
// consecutive addresses, zeroes masked columns and pushes each row into the
// weight FIFO. A 2-entry skid buffer absorbs reads still in flight when hold
// rises, so pausing never loses or duplicates a row.
module weight_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_INPUTS = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [FIFO_INPUTS-1:0]            col_mask,
  input  logic                              hold,
  output logic                              mem_rd_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  input  logic [DATA_WIDTH*FIFO_INPUTS-1:0] mem_rdata,
  output logic [FIFO_INPUTS-1:0]            fifo_en,
  output logic [DATA_WIDTH*FIFO_INPUTS-1:0] fifo_data,
  output logic                              busy,
  output logic                              done
);

  localparam int FIFO_WIDTH = DATA_WIDTH * FIFO_INPUTS;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [FIFO_INPUTS-1:0]  mask_q, mask_d;
  logic [CW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]           push_cnt_q, push_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  // Skid buffer: two entries, head pointer and occupancy.
  logic [FIFO_WIDTH-1:0]   buf_q [2];
  logic                    head_q, head_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    inflight_q;
  logic                    wr_idx;

  logic                    issue;
  logic                    pop;
  logic [2:0]              credit;
  logic [FIFO_WIDTH-1:0]   masked_rdata;

  // Zero the bytes of disabled columns before they enter the buffer.
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_INPUTS; gi++) begin : g_mask
      assign masked_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
        mask_q[gi] ? mem_rdata[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  // Control state, latched tile parameters, counters and held read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mask_q     <= '0;
      rd_cnt_q   <= '0;
      push_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mask_q     <= mask_d;
      rd_cnt_q   <= rd_cnt_d;
      push_cnt_q <= push_cnt_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state, read issue (credit-limited) and push decisions.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mask_d     = mask_q;
    rd_cnt_d   = rd_cnt_q;
    push_cnt_d = push_cnt_q;
    addr_d     = addr_q;
    issue      = 1'b0;
    pop        = 1'b0;
    credit     = {1'b0, cnt_q} + {2'b00, inflight_q};
    fifo_en    = '0;
    fifo_data  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          mask_d     = col_mask;
          rd_cnt_d   = '0;
          push_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        pop  = !hold && (cnt_q != 2'd0);
        // Occupancy the buffer will have once this cycle's pop is counted.
        credit = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue  = !hold && (rd_cnt_q < CW'(FIFO_DEPTH)) && (credit < 3'd2);
        if (issue) begin
          addr_d   = base_q + ADDR_WIDTH'(rd_cnt_q);
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop) begin
          fifo_en    = '1;
          fifo_data  = buf_q[head_q];
          push_cnt_d = push_cnt_q + 1'b1;
          if (push_cnt_q == CW'(FIFO_DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd_en = issue;
  assign mem_addr  = addr_d;

  // Write slot is the tail; when full and popping it equals the freed head.
  assign wr_idx = head_q ^ cnt_q[0];
  assign head_d = head_q ^ pop;
  assign cnt_d  = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  // Skid buffer: capture returning read data the cycle after each read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      if (inflight_q) begin
        buf_q[wr_idx] <= masked_rdata;
      end
      head_q     <= head_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: per-cycle vector table for the main load
// scenarios plus a hand-written reset-mid-load sequence.
module tb_weight_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [3:0]  col_mask;
  logic        hold;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [3:0]  fifo_en;
  logic [31:0] fifo_data;
  logic        busy;
  logic        done;

  weight_loader #(
    .DATA_WIDTH(8), .FIFO_INPUTS(4), .FIFO_DEPTH(4), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .col_mask(col_mask), .hold(hold), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fifo_en(fifo_en),
    .fifo_data(fifo_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model: data valid the cycle after the read strobe.
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= sram[mem_addr];
  end

  typedef struct {
    logic        hold;
    logic        start;
    logic [7:0]  base;
    logic [3:0]  mask;
    logic        rd;
    logic [7:0]  addr;
    logic [3:0]  en;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vec [80];
  int   nvec;
  int   split_idx;
  logic [7:0] last_addr;
  int   pass_cnt;
  int   total_cnt;

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s (step %0d): got %h expected %h", name, idx, got, exp);
  endtask

  task automatic add_vec(input logic h, input logic s, input logic [7:0] b,
                         input logic [3:0] m, input logic rd, input logic [7:0] a,
                         input logic [3:0] en, input logic [31:0] d,
                         input logic bz, input logic dn);
    vec[nvec] = '{h, s, b, m, rd, a, en, d, bz, dn};
    nvec++;
  endtask

  // Unpaused 9-cycle load: start at cycle 0, reads 1..4, pushes 3..6, done 7.
  // xcyc/xbase inject an extra start while busy.
  task automatic add_load(input logic [7:0] base, input logic [3:0] mask,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3,
                          input int xcyc, input logic [7:0] xbase);
    logic [31:0] rows [4];
    logic [7:0]  a;
    logic [3:0]  en;
    logic [31:0] d;
    logic        rd;
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    for (int c = 0; c < 9; c++) begin
      rd = (c >= 1 && c <= 4);
      if (rd)          a = base + 8'(c - 1);
      else if (c == 0) a = last_addr;
      else             a = base + 8'd3;
      en = (c >= 3 && c <= 6) ? 4'hF : 4'h0;
      d  = (c >= 3 && c <= 6) ? rows[c-3] : 32'h0;
      add_vec(1'b0, (c == 0) || (c == xcyc), (c == xcyc) ? xbase : base, mask,
              rd, a, en, d, (c >= 1 && c <= 7), (c == 7));
    end
    last_addr = base + 8'd3;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      hold = vec[i].hold; start = vec[i].start;
      base_addr = vec[i].base; col_mask = vec[i].mask;
      @(negedge clk);
      chk("mem_rd_en", i, 32'(mem_rd_en), 32'(vec[i].rd));
      chk("mem_addr",  i, 32'(mem_addr),  32'(vec[i].addr));
      chk("fifo_en",   i, 32'(fifo_en),   32'(vec[i].en));
      chk("fifo_data", i, fifo_data,      vec[i].data);
      chk("busy",      i, 32'(busy),      32'(vec[i].busy));
      chk("done",      i, 32'(done),      32'(vec[i].done));
      $display("step %0d: rd=%0b addr=%h en=%h data=%h busy=%0b done=%0b",
               i, mem_rd_en, mem_addr, fifo_en, fifo_data, busy, done);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; nvec = 0; last_addr = 8'h00;
    for (int i = 0; i < 256; i++) sram[i] = 32'h0;
    sram[8'h10] = 32'h01020304; sram[8'h11] = 32'h05060708;
    sram[8'h12] = 32'h090A0B0C; sram[8'h13] = 32'h0D0E0F10;
    sram[8'hFE] = 32'hA1A2A3A4; sram[8'hFF] = 32'hB1B2B3B4;
    sram[8'h00] = 32'hC1C2C3C4; sram[8'h01] = 32'hD1D2D3D4;
    for (int i = 8'h40; i < 8'h44; i++) sram[i] = 32'hEEEEEEEE;

    // Basic load, column mask, address wrap.
    add_load(8'h10, 4'hF, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, -1, 8'h0);
    add_load(8'h10, 4'hC, 32'h01020000, 32'h05060000, 32'h090A0000, 32'h0D0E0000, -1, 8'h0);
    add_load(8'hFE, 4'hF, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4, -1, 8'h0);
    // Hold in cycles 3-5: reads resume cycle 6, pushes 6..9, done cycle 10.
    add_vec(0, 1, 8'h10, 4'hF, 0, 8'h01, 4'h0, 32'h0, 0, 0);
    add_vec(0, 0, 8'h10, 4'hF, 1, 8'h10, 4'h0, 32'h0, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 1, 8'h11, 4'h0, 32'h0, 1, 0);
    add_vec(1, 0, 8'h10, 4'hF, 0, 8'h11, 4'h0, 32'h0, 1, 0);
    add_vec(1, 0, 8'h10, 4'hF, 0, 8'h11, 4'h0, 32'h0, 1, 0);
    add_vec(1, 0, 8'h10, 4'hF, 0, 8'h11, 4'h0, 32'h0, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 1, 8'h12, 4'hF, 32'h01020304, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 1, 8'h13, 4'hF, 32'h05060708, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 0, 8'h13, 4'hF, 32'h090A0B0C, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 0, 8'h13, 4'hF, 32'h0D0E0F10, 1, 0);
    add_vec(0, 0, 8'h10, 4'hF, 0, 8'h13, 4'h0, 32'h0, 1, 1);
    add_vec(0, 0, 8'h10, 4'hF, 0, 8'h13, 4'h0, 32'h0, 0, 0);
    last_addr = 8'h13;
    // Start while busy at cycle 2 with base 0x40 must be ignored.
    add_load(8'h10, 4'hF, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 2, 8'h40);
    split_idx = nvec;
    // Clean load after the mid-load reset; reset leaves mem_addr at 0.
    last_addr = 8'h00;
    add_load(8'h10, 4'hF, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, -1, 8'h0);

    // Reset state, with start asserted alongside reset (reset wins).
    reset = 1'b1; start = 1'b1; hold = 1'b0; base_addr = 8'h10; col_mask = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 0, 32'(mem_rd_en), 32'h0);
    chk("rst_addr",  0, 32'(mem_addr),  32'h0);
    chk("rst_en",    0, 32'(fifo_en),   32'h0);
    chk("rst_data",  0, fifo_data,      32'h0);
    chk("rst_busy",  0, 32'(busy),      32'h0);
    chk("rst_done",  0, 32'(done),      32'h0);
    $display("reset: rd=%0b addr=%h en=%h busy=%0b done=%0b", mem_rd_en, mem_addr, fifo_en, busy, done);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    run_vecs(0, split_idx);

    // Reset mid-load: start at cycle 0, reset asserted in cycle 4.
    start = 1'b1; base_addr = 8'h10; col_mask = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("mrst_rd_en", c, 32'(mem_rd_en), 32'h1);
      chk("mrst_addr",  c, 32'(mem_addr),  32'h10 + 32'(c - 1));
      chk("mrst_en",    c, 32'(fifo_en),   (c == 3) ? 32'hF : 32'h0);
      $display("midreset cycle %0d: rd=%0b addr=%h en=%h data=%h", c, mem_rd_en, mem_addr, fifo_en, fifo_data);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("mrst_now_rd_en", 4, 32'(mem_rd_en), 32'h0);
    chk("mrst_now_addr",  4, 32'(mem_addr),  32'h0);
    chk("mrst_now_en",    4, 32'(fifo_en),   32'h0);
    chk("mrst_now_data",  4, fifo_data,      32'h0);
    chk("mrst_now_busy",  4, 32'(busy),      32'h0);
    $display("midreset cycle 4: reset asserted, rd=%0b addr=%h en=%h busy=%0b", mem_rd_en, mem_addr, fifo_en, busy);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      chk("post_rst_en",   c, 32'(fifo_en), 32'h0);
      chk("post_rst_done", c, 32'(done),    32'h0);
      chk("post_rst_busy", c, 32'(busy),    32'h0);
      $display("post-reset cycle %0d: en=%h busy=%0b done=%0b", c, fifo_en, busy, done);
      @(posedge clk); #1;
    end

    run_vecs(split_idx, nvec);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
